// File: rtl/fp_alu_issuer.sv
// Issues commands to a fixed-latency pipelined FP ALU, tracks each one with a
// tag pipeline, and queues tagged results in a credit-protected result FIFO.
module fp_alu_issuer #(
  parameter int ALU_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ID_W        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [31:0]     cmd_a,
  input  logic [31:0]     cmd_b,
  input  logic [ID_W-1:0] cmd_id,
  output logic [31:0]     alu_para1,
  output logic [31:0]     alu_para2,
  output logic [1:0]      alu_op,
  input  logic [31:0]     alu_out,
  input  logic            alu_zero,
  input  logic            alu_uo,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_data,
  output logic            res_zero,
  output logic            res_uo,
  output logic [ID_W-1:0] res_id,
  output logic            busy
);
  localparam int DATA_W = 32;
  localparam int STAGES = ALU_LATENCY + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = $clog2(FIFO_DEPTH + STAGES + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              uo;
    logic [ID_W-1:0]   id;
  } entry_t;

  logic [DATA_W-1:0] para1_q, para1_d;
  logic [DATA_W-1:0] para2_q, para2_d;
  logic [1:0]        op_q, op_d;
  logic [STAGES-1:0] vld_p_q, vld_p_d;
  logic [ID_W-1:0]   id_p_q [STAGES];
  logic [ID_W-1:0]   id_p_d [STAGES];
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SUM_W-1:0]  inflight;
  logic [SUM_W-1:0]  outstanding;
  logic              issue;
  logic              push;
  logic              pop;
  entry_t            head;

  // Credit: every in-flight op already owns a FIFO slot, so a push can never find it full.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) inflight = inflight + SUM_W'(vld_p_q[i]);
    outstanding = inflight + SUM_W'(count_q);
  end

  assign cmd_ready = rst_n && (outstanding < SUM_W'(FIFO_DEPTH));
  assign issue     = cmd_valid && cmd_ready;
  assign push      = vld_p_q[STAGES-1];
  assign pop       = res_valid && res_ready;

  always_comb begin
    para1_d = para1_q;
    para2_d = para2_q;
    op_d    = op_q;
    if (issue) begin
      para1_d = cmd_a;
      para2_d = cmd_b;
      op_d    = cmd_op;
    end
    // Tag stage 0 aligns with the ALU operand register; the last stage with alu_out.
    vld_p_d   = {vld_p_q[STAGES-2:0], issue};
    id_p_d[0] = cmd_id;
    for (int i = 1; i < STAGES; i++) id_p_d[i] = id_p_q[i-1];

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {alu_out, alu_zero, alu_uo, id_p_q[STAGES-1]};
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      para1_q  <= '0;
      para2_q  <= '0;
      op_q     <= '0;
      vld_p_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      para1_q  <= para1_d;
      para2_q  <= para2_d;
      op_q     <= op_d;
      vld_p_q  <= vld_p_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tags and FIFO storage are qualified by the valid bits and count, so they need no reset.
  always_ff @(posedge clk) begin
    id_p_q <= id_p_d;
    mem_q  <= mem_d;
  end

  assign head      = mem_q[rd_ptr_q];
  assign res_valid = (count_q != '0);
  assign res_data  = res_valid ? head.data : '0;
  assign res_zero  = res_valid ? head.zero : 1'b0;
  assign res_uo    = res_valid ? head.uo   : 1'b0;
  assign res_id    = res_valid ? head.id   : '0;
  assign busy      = (inflight != '0) || res_valid;

  assign alu_para1 = para1_q;
  assign alu_para2 = para2_q;
  assign alu_op    = op_q;
endmodule

// File: tb/tb_fp_alu_issuer.sv
// Bench for fp_alu_issuer: a behavioural two-register FP ALU plus a queue-based
// reference model of issue, credit and result ordering.
module tb_fp_alu_issuer;
  localparam int ALU_LATENCY = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int ID_W        = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [31:0]     cmd_a = '0;
  logic [31:0]     cmd_b = '0;
  logic [ID_W-1:0] cmd_id = '0;
  logic [31:0]     alu_para1, alu_para2;
  logic [1:0]      alu_op;
  logic [31:0]     alu_out = 32'hDEAD_BEEF;
  logic            alu_zero = 1'b1;
  logic            alu_uo = 1'b1;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [31:0]     res_data;
  logic            res_zero, res_uo;
  logic [ID_W-1:0] res_id;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] vals [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F00_0000,
                            32'hBFC0_0000, 32'h4080_0000, 32'hC000_0000, 32'h3E80_0000};

  typedef struct {
    logic [33:0]     r;
    logic [ID_W-1:0] id;
    int              rdy;
  } exp_t;

  always #5 clk = ~clk;

  fp_alu_issuer #(.ALU_LATENCY(ALU_LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_id(cmd_id),
    .alu_para1(alu_para1), .alu_para2(alu_para2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_uo(alu_uo),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_uo(res_uo), .res_id(res_id), .busy(busy)
  );

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    while (e > 127) begin m = m * 2.0; e--; end
    while (e < 127) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // {out, zero, under_overflow} of the floating-point operation.
  function automatic logic [33:0] ref_fp(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    real         r;
    logic [31:0] o;
    case (op)
      2'b00:   r = f2r(a) + f2r(b);
      2'b01:   r = f2r(a) - f2r(b);
      2'b10:   r = f2r(a) * f2r(b);
      default: return {32'h0, 1'b1, 1'b0};
    endcase
    o = r2f(r);
    return {o, (o[30:0] == 31'h0), 1'b0};
  endfunction

  // ALU: input register then output register; outputs are unreset garbage at start.
  logic [31:0] alu_in_a = 32'h1234_5678;
  logic [31:0] alu_in_b = 32'hCAFE_F00D;
  logic [1:0]  alu_in_op = 2'b10;
  always @(posedge clk) begin
    alu_in_a  <= alu_para1;
    alu_in_b  <= alu_para2;
    alu_in_op <= alu_op;
    {alu_out, alu_zero, alu_uo} <= ref_fp(alu_in_op, alu_in_a, alu_in_b);
  end

  always @(posedge clk) begin
    if (rst_n && dut.push && !dut.pop && (int'(dut.count_q) == FIFO_DEPTH)) begin
      errors++;
      $display("FAIL push_while_full count=%0d", dut.count_q);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
    checks++; if (alu_para1 !== 32'h0) begin errors++; $display("FAIL rst_para1 got %h want 0", alu_para1); end
    checks++; if (alu_para2 !== 32'h0) begin errors++; $display("FAIL rst_para2 got %h want 0", alu_para2); end
    checks++; if (alu_op !== 2'b00) begin errors++; $display("FAIL rst_op got %b want 00", alu_op); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if ({res_data, res_zero, res_uo, res_id} !== '0) begin
      errors++; $display("FAIL rst_res_fields got %h/%b/%b/%h want 0", res_data, res_zero, res_uo, res_id);
    end
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cmd_ready got %b want 1", cmd_ready); end
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL post_rst_idle got valid=%b busy=%b want 0/0", res_valid, busy);
      end
    end
  endtask

  task automatic test_single_op(input string name, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [ID_W-1:0] id,
                                input logic [31:0] exp_data, input logic exp_zero);
    res_ready = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_id = id; cmd_valid = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got %b want 1", name, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    cmd_a = ~a; cmd_b = ~b;
    checks++; if ({alu_para1, alu_para2, alu_op} !== {a, b, op}) begin
      errors++; $display("FAIL %s_alu_drive got %h %h %b want %h %h %b", name, alu_para1, alu_para2, alu_op, a, b, op);
    end
    checks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL %s_k got busy=%b valid=%b want 1/0", name, busy, res_valid);
    end
    for (int t = 1; t <= 2; t++) begin
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid edge k+%0d got %b want 0", name, t, res_valid); end
    end
    checks++; if (alu_para1 !== a) begin errors++; $display("FAIL %s_hold got %h want %h", name, alu_para1, a); end
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b want 1", name, res_valid); end
    checks++; if ({res_data, res_zero, res_uo, res_id} !== {exp_data, exp_zero, 1'b0, id}) begin
      errors++; $display("FAIL %s_result got %h z%b uo%b id%h want %h z%b uo0 id%h",
                         name, res_data, res_zero, res_uo, res_id, exp_data, exp_zero, id);
    end
    tick();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_drained got valid=%b busy=%b want 0/0", name, res_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [1:0]  op [3];
    logic [33:0] r;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a[i] = vals[$urandom_range(0, 7)]; b[i] = vals[$urandom_range(0, 7)]; op[i] = 2'($urandom_range(0, 2));
    end
    for (int t = 0; t <= 6; t++) begin
      if (t < 3) begin
        cmd_valid = 1'b1; cmd_op = op[t]; cmd_a = a[t]; cmd_b = b[t]; cmd_id = 4'(t + 1);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cmd %0d got %b want 1", t, cmd_ready); end
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      if (t >= 3 && t <= 5) begin
        r = ref_fp(op[t-3], a[t-3], b[t-3]);
        checks++; if ({res_valid, res_id, res_data, res_zero, res_uo} !== {1'b1, 4'(t - 2), r}) begin
          errors++; $display("FAIL b2b_result edge k+%0d got v%b id%h %h want v1 id%h %h",
                             t, res_valid, res_id, res_data, 4'(t - 2), r[33:2]);
        end
      end else begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle edge k+%0d got %b want 0", t, res_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    int   dut_hs = 0;
    int   pops = 0;
    res_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      cmd_valid = 1'b1; cmd_op = 2'($urandom_range(0, 3));
      cmd_a = vals[$urandom_range(0, 7)]; cmd_b = vals[$urandom_range(0, 7)]; cmd_id = 4'(t + 8);
      #1;
      checks++; if (cmd_ready !== (q.size() < FIFO_DEPTH)) begin
        errors++; $display("FAIL bp_ready cycle %0d got %b want %b", t, cmd_ready, q.size() < FIFO_DEPTH);
      end
      if (cmd_valid && cmd_ready) dut_hs++;
      if (q.size() < FIFO_DEPTH) q.push_back('{r: ref_fp(cmd_op, cmd_a, cmd_b), id: cmd_id, rdy: 0});
      tick();
    end
    cmd_valid = 1'b0;
    checks++; if (dut_hs != FIFO_DEPTH) begin errors++; $display("FAIL bp_handshakes got %0d want %0d", dut_hs, FIFO_DEPTH); end
    checks++; if (busy !== 1'b1 || res_valid !== 1'b1) begin
      errors++; $display("FAIL bp_full got busy=%b valid=%b want 1/1", busy, res_valid);
    end
    res_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      #1;
      if (t == 0) begin
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_during_pop got %b want 0", cmd_ready); end
      end
      if (t == 1) begin
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b want 1", cmd_ready); end
      end
      checks++; if (res_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL bp_drain_valid step %0d got %b want %b", t, res_valid, q.size() != 0);
      end
      if (res_valid && q.size() != 0) begin
        checks++; if ({res_data, res_zero, res_uo, res_id} !== {q[0].r, q[0].id}) begin
          errors++; $display("FAIL bp_drain_data step %0d got %h id%h want %h id%h", t, res_data, res_id, q[0].r[33:2], q[0].id);
        end
        void'(q.pop_front());
        pops++;
      end
      tick();
    end
    checks++; if (pops != FIFO_DEPTH || busy !== 1'b0) begin
      errors++; $display("FAIL bp_pops got %0d busy=%b want %0d busy=0", pops, busy, FIFO_DEPTH);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    int   outstanding = 0;
    logic exp_rdy, exp_vld;
    for (int t = 0; t < 320; t++) begin
      cmd_valid = (t < 300) && ($urandom_range(0, 3) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_a     = vals[$urandom_range(0, 7)];
      cmd_b     = vals[$urandom_range(0, 7)];
      cmd_id    = 4'($urandom);
      res_ready = (t >= 300) || ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = (outstanding < FIFO_DEPTH);
      exp_vld = (q.size() != 0) && (q[0].rdy <= cyc);
      checks++; if (cmd_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, cmd_ready, exp_rdy); end
      checks++; if (busy !== (outstanding != 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, outstanding != 0); end
      checks++; if (res_valid !== exp_vld) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, res_valid, exp_vld); end
      if (exp_vld) begin
        checks++; if ({res_data, res_zero, res_uo, res_id} !== {q[0].r, q[0].id}) begin
          errors++; $display("FAIL rnd_result cyc %0d got %h z%b uo%b id%h want %h z%b uo%b id%h", cyc,
                             res_data, res_zero, res_uo, res_id, q[0].r[33:2], q[0].r[1], q[0].r[0], q[0].id);
        end
      end
      if (cmd_valid && exp_rdy) begin
        q.push_back('{r: ref_fp(cmd_op, cmd_a, cmd_b), id: cmd_id, rdy: cyc + ALU_LATENCY + 2});
        outstanding++;
      end
      if (exp_vld && res_ready) begin
        void'(q.pop_front());
        outstanding--;
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    res_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = vals[t]; cmd_b = vals[t + 2]; cmd_id = 4'(t + 12);
      tick();
    end
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", cmd_ready); end
    tick();
    checks++; if ({alu_para1, alu_para2, alu_op} !== '0) begin
      errors++; $display("FAIL mid_rst_alu got %h %h %b want 0", alu_para1, alu_para2, alu_op);
    end
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_rst_idle step %0d got valid=%b busy=%b want 0/0", t, res_valid, busy);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_op("add", 2'b00, 32'h3F80_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 1'b0);
    test_single_op("sub_zero", 2'b01, 32'h4000_0000, 32'h4000_0000, 4'd9, 32'h0000_0000, 1'b1);
    test_single_op("mul", 2'b10, 32'h4000_0000, 32'h4040_0000, 4'd14, 32'h40C0_0000, 1'b0);
    test_single_op("reserved", 2'b11, 32'h3F80_0000, 32'h4080_0000, 4'd7, 32'h0000_0000, 1'b1);
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
